hmmm_mem_responder: RTL and testbench
=====================================

// Module: hmmm_mem_responder
// PURPOSE
//   Memory-side responder for the 8-bit HMMM processor bus. Holds 2^ADDR_W 15-bit words.
//   Serves instruction/data reads on Adr/MemData1/MemData2 and captures processor stores.
//   Contains a byte-stream program loader: a host pushes start address, word count and
//   word bytes over a valid/ready handshake. The processor is held in reset while it loads.
// PARAMETERS
//   ADDR_W  8  address width; depth = 2**ADDR_W words
//   HI_W    7  upper word field width, maps to MemData1[14:8]
//   LO_W    8  lower word field width, maps to MemData2[7:0]
// PORTS
//   clk        in     1       single clock, rising-edge
//   reset      in     1       asynchronous, active-low (0 = in reset)
//   Adr        in     ADDR_W  processor address
//   MemWrite   in     1       processor store strobe (active-high)
//   MemData1   out    HI_W    read data [14:8] to processor
//   MemData2   inout  LO_W    read data [7:0] out / store data in (bidirectional)
//   cpu_reset  out    1       active-high reset to processor
//   ld_start   in     1       one-cycle pulse: begin load
//   ld_valid   in     1       host byte valid
//   ld_data    in     8       host byte
//   ld_ready   out    1       responder accepts ld_data this cycle
//   ld_busy    out    1       load in progress
//   ld_err     out    1       sticky: hi byte had bit7 set
// BEHAVIOUR
//   Reset (reset=0): state=RELEASE, cpu_reset=1, ld_ready=0, ld_busy=0, ld_err=0.
//     Internal ptr/count = 0. Memory array is NOT cleared.
//   Read path is combinational: MemData1 = mem[Adr][14:8].
//     MemData2 is driven with mem[Adr][7:0] when state=RUN & MemWrite=0; otherwise Z.
//   Store: in RUN, at the edge where MemWrite=1, mem[Adr] <= {HI_W'0, MemData2}.
//     The upper field is cleared. MemWrite is ignored in every state except RUN.
//   States:
//     RELEASE: cpu_reset=1 for exactly one cycle, then RUN.
//     RUN: cpu_reset=0. ld_start=1 -> LD_ADDR.
//     LD_ADDR, LD_CNT, LD_HI, LD_LO: cpu_reset=1, ld_busy=1, ld_ready=1.
//       A byte is accepted only on ld_valid & ld_ready.
//       LD_ADDR accept: ptr <= ld_data -> LD_CNT.
//       LD_CNT accept: count <= ld_data, where 0 means 256 words -> LD_HI.
//       LD_HI accept: hold ld_data[6:0]; if ld_data[7]=1 set ld_err -> LD_LO.
//       LD_LO accept: mem[ptr] <= {held, ld_data}; ptr <= ptr+1; count <= count-1.
//         If count was 1 -> RELEASE, else -> LD_HI.
//     ld_valid=0 in any LD_* state: hold state; no timeout.
//   ptr wraps 255 -> 0 modulo 2**ADDR_W. No error is raised on wrap.
//   ld_err is cleared only by the next ld_start accepted in RUN, or by reset.
//   ld_start outside RUN is ignored.
//   ld_start and MemWrite in the same RUN cycle: the store completes that edge, then LD_ADDR.
//   Reset asserted mid-load: the load aborts. Words already written are kept.
//     Remaining words are not written. Exit is via RELEASE.
//   Latency: a processor store is visible on the next cycle's read.
//     After the final LD_LO accept, cpu_reset is 1 for one more cycle (RELEASE), then 0.
// TESTING
//   T1 Reset release: reset 0->1 -> cpu_reset=1 for exactly 1 clk, then 0; ld_ready=0.
//   T2 Load: ld_start, bytes 0x10,0x02,0x45,0xA3,0x7F,0x01.
//      Result: mem[0x10]=0x45A3, mem[0x11]=0x7F01; cpu_reset released 1 clk later.
//   T3 Wrap + backpressure: addr 0xFF, count 2, ld_valid gaps between bytes.
//      Result: mem[0xFF] and mem[0x00] written; no extra accepts while ld_valid=0.
//   T4 Store/read: RUN, Adr=0x20, MemWrite=1, MemData2=0x5C.
//      Next cycle with MemWrite=0: MemData1=0, MemData2=0x5C.
//      During the store cycle the responder releases MemData2 (no contention).
//   T5 Error + abort: hi byte 0x80 -> ld_err=1.
//      Reset pulsed mid-load -> ld_err=0, prior words kept, count-remaining words unchanged.
//   T6 Collision: ld_start with MemWrite=1 in the same cycle -> store lands;
//      ld_start during LD_HI is ignored.

Source files
------------

// File: rtl/hmmm_mem_responder.sv
// Memory-side responder for the 8-bit HMMM bus: word store with combinational read path,
// processor store capture, and a byte-stream program loader that holds the CPU in reset.
module hmmm_mem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned HI_W   = 7,
    parameter int unsigned LO_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Adr,
    input  logic              MemWrite,
    output logic [HI_W-1:0]   MemData1,
    inout  wire  [LO_W-1:0]   MemData2,
    output logic              cpu_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_err
);

    localparam int unsigned WORD_W = HI_W + LO_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [2:0] {
        RELEASE,
        RUN,
        LD_ADDR,
        LD_CNT,
        LD_HI,
        LD_LO
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [CNT_W-1:0]    count;
    logic [HI_W-1:0]     held;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   rd_word;
    logic                acc;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;

    assign acc      = ld_valid & ld_ready;
    assign rd_word  = mem[Adr];
    assign MemData1 = rd_word[WORD_W-1:LO_W];
    // Drive the low byte only when the processor is reading; released during stores and loads
    assign MemData2 = (state == RUN && !MemWrite) ? rd_word[LO_W-1:0] : {LO_W{1'bz}};

    // Single write port shared by processor stores (RUN) and loader words (LD_LO)
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = Adr;
        wr_data = {HI_W'(0), MemData2};
        if (state == RUN && MemWrite) begin
            wr_en = 1'b1;
        end else if (state == LD_LO && acc) begin
            wr_en   = 1'b1;
            wr_addr = ptr;
            wr_data = {held, LO_W'(ld_data)};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RELEASE;
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b0;
            ld_busy   <= 1'b0;
            ld_err    <= 1'b0;
            ptr       <= '0;
            count     <= '0;
            held      <= '0;
        end else begin
            case (state)
                RELEASE: begin
                    state     <= RUN;
                    cpu_reset <= 1'b0;
                    ld_ready  <= 1'b0;
                    ld_busy   <= 1'b0;
                end
                RUN: begin
                    if (ld_start) begin
                        state     <= LD_ADDR;
                        cpu_reset <= 1'b1;
                        ld_ready  <= 1'b1;
                        ld_busy   <= 1'b1;
                        ld_err    <= 1'b0;
                    end
                end
                LD_ADDR: begin
                    if (acc) begin
                        ptr   <= ADDR_W'(ld_data);
                        state <= LD_CNT;
                    end
                end
                LD_CNT: begin
                    if (acc) begin
                        count <= (ld_data == 8'd0) ? CNT_W'(256) : CNT_W'(ld_data);
                        state <= LD_HI;
                    end
                end
                LD_HI: begin
                    if (acc) begin
                        held <= ld_data[HI_W-1:0];
                        if (ld_data[7]) begin
                            ld_err <= 1'b1;
                        end
                        state <= LD_LO;
                    end
                end
                LD_LO: begin
                    if (acc) begin
                        ptr   <= ptr + ADDR_W'(1);
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state    <= RELEASE;
                            ld_ready <= 1'b0;
                            ld_busy  <= 1'b0;
                        end else begin
                            state <= LD_HI;
                        end
                    end
                end
                default: begin
                    state     <= RELEASE;
                    cpu_reset <= 1'b1;
                    ld_ready  <= 1'b0;
                    ld_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Scoreboard bench for hmmm_mem_responder: expected words are queued as stimulus is
// driven and popped when read back through Adr/MemData1/MemData2.
module tb_hmmm_mem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned HI_W   = 7;
    localparam int unsigned LO_W   = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [14:0] word;
    } sb_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] Adr = '0;
    logic              MemWrite = 1'b0;
    logic [HI_W-1:0]   MemData1;
    wire  [LO_W-1:0]   MemData2;
    logic              cpu_reset;
    logic              ld_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_data = '0;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_err;
    logic [LO_W-1:0]   drv = '0;
    logic              drv_en = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    sb_t         sb [$];
    logic [14:0] model [256];
    bit          model_v [256];

    assign MemData2 = drv_en ? drv : {LO_W{1'bz}};

    always #5 clk = ~clk;

    hmmm_mem_responder #(.ADDR_W(ADDR_W), .HI_W(HI_W), .LO_W(LO_W)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .MemWrite(MemWrite),
        .MemData1(MemData1), .MemData2(MemData2), .cpu_reset(cpu_reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_err(ld_err)
    );

    // {cpu_reset, ld_ready, ld_busy, ld_err}
    function automatic logic [3:0] status();
        return {cpu_reset, ld_ready, ld_busy, ld_err};
    endfunction

    task automatic put(input logic [7:0] a, input logic [14:0] w);
        sb_t e;
        model[a]   = w;
        model_v[a] = 1'b1;
        e.addr = a;
        e.word = w;
        sb.push_back(e);
    endtask

    task automatic recall(input logic [7:0] a);
        sb_t e;
        e.addr = a;
        e.word = model[a];
        sb.push_back(e);
    endtask

    // Must be called in RUN so the responder drives MemData2
    task automatic drain_sb(input string tag);
        sb_t e;
        logic [14:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            Adr = e.addr;
            MemWrite = 1'b0;
            drv_en = 1'b0;
            #1;
            got = {MemData1, MemData2};
            n_cmp++;
            if (got !== e.word) begin
                n_bad++;
                $display("FAIL %s read[%02h]: got %04h want %04h", tag, e.addr, got, e.word);
            end
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        repeat (gaps) begin
            ld_valid = 1'b0;
            ld_data  = 8'hEE;
            @(negedge clk);
        end
        ld_valid = 1'b1;
        ld_data  = b;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 8'hEE;
    endtask

    task automatic start_load(input logic [7:0] a, input logic [7:0] c);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        send_byte(a, 0);
        send_byte(c, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 1000", status());
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL release_hold: got %b want 1000", status());
        end
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b0000) begin
            n_bad++;
            $display("FAIL release_run: got %b want 0000", status());
        end
    endtask

    task automatic test_load();
        start_load(8'h10, 8'h02);
        n_cmp++;
        if (status() !== 4'b1110) begin
            n_bad++;
            $display("FAIL load_busy: got %b want 1110", status());
        end
        send_byte(8'h45, 0);
        send_byte(8'hA3, 0);
        put(8'h10, 15'h45A3);
        send_byte(8'h7F, 0);
        send_byte(8'h01, 0);
        put(8'h11, 15'h7F01);
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL load_release: got %b want 1000", status());
        end
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b0000) begin
            n_bad++;
            $display("FAIL load_run: got %b want 0000", status());
        end
        drain_sb("load");
    endtask

    task automatic test_wrap_backpressure();
        start_load(8'hFF, 8'h02);
        send_byte(8'h12, 3);
        send_byte(8'h34, 2);
        put(8'hFF, 15'h1234);
        n_cmp++;
        if (status() !== 4'b1110) begin
            n_bad++;
            $display("FAIL gap_still_busy: got %b want 1110", status());
        end
        send_byte(8'h55, 4);
        send_byte(8'h66, 1);
        put(8'h00, 15'h5566);
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_release: got %b want 1000", status());
        end
        @(negedge clk);
        drain_sb("wrap");
    endtask

    task automatic test_store_read();
        Adr = 8'h20;
        MemWrite = 1'b1;
        drv = 8'h5C;
        drv_en = 1'b1;
        #1;
        n_cmp++;
        if (MemData2 !== 8'h5C) begin
            n_bad++;
            $display("FAIL store_bus_release: got %02h want 5c", MemData2);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        drv_en = 1'b0;
        #1;
        n_cmp++;
        if ({MemData1, MemData2} !== 15'h005C) begin
            n_bad++;
            $display("FAIL store_next_read: got %04h want 005c", {MemData1, MemData2});
        end
        model[8'h20] = 15'h005C;
        model_v[8'h20] = 1'b1;
        // Overwrite a loaded word: the upper field must clear
        @(negedge clk);
        Adr = 8'h11;
        MemWrite = 1'b1;
        drv = 8'hC4;
        drv_en = 1'b1;
        @(negedge clk);
        Adr = 8'h32;
        drv = 8'hAB;
        @(negedge clk);
        MemWrite = 1'b0;
        drv_en = 1'b0;
        put(8'h11, 15'h00C4);
        put(8'h32, 15'h00AB);
        drain_sb("store");
    endtask

    task automatic test_err_abort();
        start_load(8'h60, 8'h01);
        send_byte(8'h81, 0);
        send_byte(8'h22, 0);
        put(8'h60, 15'h0122);
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b0001) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 0001", status());
        end
        start_load(8'h30, 8'h03);
        n_cmp++;
        if (status() !== 4'b1110) begin
            n_bad++;
            $display("FAIL err_clear_on_start: got %b want 1110", status());
        end
        send_byte(8'h80, 0);
        send_byte(8'h11, 0);
        put(8'h30, 15'h0011);
        n_cmp++;
        if (status() !== 4'b1111) begin
            n_bad++;
            $display("FAIL err_set: got %b want 1111", status());
        end
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        put(8'h31, 15'h0506);
        send_byte(8'h07, 0);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL abort_reset: got %b want 1000", status());
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL abort_release: got %b want 1000", status());
        end
        @(negedge clk);
        n_cmp++;
        if (status() !== 4'b0000) begin
            n_bad++;
            $display("FAIL abort_run: got %b want 0000", status());
        end
        recall(8'h32);
        drain_sb("abort");
    endtask

    task automatic test_collision();
        Adr = 8'h40;
        MemWrite = 1'b1;
        drv = 8'h3C;
        drv_en = 1'b1;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        MemWrite = 1'b0;
        drv_en = 1'b0;
        n_cmp++;
        if (status() !== 4'b1110) begin
            n_bad++;
            $display("FAIL collide_start: got %b want 1110", status());
        end
        // Store attempt while loading must be ignored
        Adr = 8'h10;
        MemWrite = 1'b1;
        drv = 8'h99;
        drv_en = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        drv_en = 1'b0;
        send_byte(8'h50, 0);
        send_byte(8'h01, 0);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        n_cmp++;
        if (status() !== 4'b1000) begin
            n_bad++;
            $display("FAIL start_in_ld_hi: got %b want 1000", status());
        end
        @(negedge clk);
        put(8'h40, 15'h003C);
        put(8'h50, 15'h0102);
        recall(8'h10);
        drain_sb("collide");
    endtask

    task automatic test_full_sweep();
        for (int a = 0; a < 256; a++) begin
            if (model_v[a]) recall(8'(a));
        end
        drain_sb("sweep");
    endtask

    initial begin
        for (int a = 0; a < 256; a++) model_v[a] = 1'b0;
        test_reset();
        test_load();
        test_wrap_backpressure();
        test_store_read();
        test_err_abort();
        test_collision();
        test_full_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
